// File: rtl/i2s_rx_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_deser_pkg
//  Description : Shared audio package. Holds the I2S receiver FSM encoding,
//                the bit-counter saturation constant, the common sample type
//                and a saturating counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_rx_deser_pkg;

    // Receiver FSM encoding
    localparam int unsigned        STATE_W  = 2;
    localparam logic [STATE_W-1:0] ST_SEEK  = 2'd0;
    localparam logic [STATE_W-1:0] ST_LEFT  = 2'd1;
    localparam logic [STATE_W-1:0] ST_RIGHT = 2'd2;

    // Per-word bit counter: wide enough for a 64-bit slot, saturates at 63
    localparam int unsigned      CNT_W   = 6;
    localparam logic [CNT_W-1:0] CNT_SAT = 6'd63;

    // Sample width type shared with downstream filter blocks
    localparam int unsigned SAMPLE_W = 16;
    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_SAT) ? cnt : cnt + 6'd1;
    endfunction

endpackage : i2s_rx_deser_pkg
`default_nettype wire

// File: rtl/sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : STAGES-deep single-bit synchronizer into the clk domain.
//  Ports       : clk  - destination clock
//                rst  - asynchronous active-high reset, clears every stage
//                i_d  - asynchronous input bit
//                o_q  - synchronized output bit
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    generate
        if (STAGES <= 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_q <= 1'b0;
                else     r_q <= i_d;
            end
            assign o_q = r_q;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_chain <= '0;
                else     r_chain <= {r_chain[STAGES-2:0], i_d};
            end
            assign o_q = r_chain[STAGES-1];
        end
    endgenerate

endmodule : sync_bit
`default_nettype wire

// File: rtl/i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_deser
//  Description : I2S ADC receiver. Oversamples the codec bit clock with MCLK,
//                deserializes left/right words (MSB first, one-bit WS delay)
//                and presents complete stereo pairs on LDATA/RDATA.
//  Ports       : MCLK      - sole clock, rising edge
//                RST       - asynchronous active-high reset
//                ABCLK     - codec bit clock (async, >= 4 MCLK per period)
//                ALRCLK    - word select, 0 = left, 1 = right
//                ADATA     - serial data
//                LDATA     - last complete left sample
//                RDATA     - last complete right sample
//                FSCLK     - one-cycle pulse: new pair on LDATA/RDATA
//                LOCKED    - frame alignment acquired
//                FRAME_ERR - one-cycle pulse: word shorter than WIDTH ended
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deser #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             MCLK,
    input  logic             RST,
    input  logic             ABCLK,
    input  logic             ALRCLK,
    input  logic             ADATA,
    output logic [WIDTH-1:0] LDATA,
    output logic [WIDTH-1:0] RDATA,
    output logic             FSCLK,
    output logic             LOCKED,
    output logic             FRAME_ERR
);

    import i2s_rx_deser_pkg::*;

    localparam logic [CNT_W-1:0] c_width    = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_width_m1 = CNT_W'(WIDTH - 1);

    logic             w_bclk_s;
    logic             w_ws_s;
    logic             w_data_s;
    logic             w_rise;
    logic             w_boundary;
    logic             w_short;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_word;

    logic               r_bclk_d;
    logic               r_ws_d;
    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_hold;
    logic [WIDTH-1:0]   r_ldata;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_pair_done;
    logic               r_fsclk;
    logic               r_locked;
    logic               r_frame_err;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_bclk (
        .clk (MCLK), .rst (RST), .i_d (ABCLK),  .o_q (w_bclk_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk (MCLK), .rst (RST), .i_d (ALRCLK), .o_q (w_ws_s)
    );
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_data (
        .clk (MCLK), .rst (RST), .i_d (ADATA),  .o_q (w_data_s)
    );

    assign w_rise       = w_bclk_s & ~r_bclk_d;
    assign w_boundary   = w_ws_s ^ r_ws_d;
    assign w_shift_next = {r_shift[WIDTH-2:0], w_data_s};
    // The bit on the boundary rise is the LSB of the ending word: it is part
    // of the word only while fewer than WIDTH bits have been collected.
    assign w_word       = (r_cnt < c_width) ? w_shift_next : r_shift;
    // r_cnt excludes the boundary bit, so the word length is r_cnt + 1.
    assign w_short      = (r_cnt < c_width_m1);

    always_ff @(posedge MCLK or posedge RST) begin
        if (RST) begin
            r_bclk_d    <= 1'b0;
            r_ws_d      <= 1'b0;
            r_state     <= ST_SEEK;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_ldata     <= '0;
            r_rdata     <= '0;
            r_pair_done <= 1'b0;
            r_fsclk     <= 1'b0;
            r_locked    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_bclk_d    <= w_bclk_s;
            r_pair_done <= 1'b0;
            // FSCLK trails the data update by one cycle so LDATA/RDATA are
            // already stable when the pulse is seen.
            r_fsclk     <= r_pair_done;
            r_frame_err <= 1'b0;

            if (w_rise) begin
                r_ws_d <= w_ws_s;
                if (w_boundary) begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    case (r_state)
                        ST_SEEK: begin
                            if (!w_ws_s) r_state <= ST_LEFT;
                        end
                        ST_LEFT: begin
                            if (w_short) begin
                                r_frame_err <= 1'b1;
                                r_locked    <= 1'b0;
                                r_state     <= ST_SEEK;
                            end else begin
                                r_hold  <= w_word;
                                r_state <= ST_RIGHT;
                            end
                        end
                        ST_RIGHT: begin
                            if (w_short) begin
                                r_frame_err <= 1'b1;
                                r_locked    <= 1'b0;
                                r_state     <= ST_SEEK;
                            end else begin
                                r_ldata     <= r_hold;
                                r_rdata     <= w_word;
                                r_pair_done <= 1'b1;
                                r_locked    <= 1'b1;
                                r_state     <= ST_LEFT;
                            end
                        end
                        default: r_state <= ST_SEEK;
                    endcase
                end else begin
                    r_cnt <= cnt_inc(r_cnt);
                    if (r_cnt < c_width) r_shift <= w_shift_next;
                end
            end
        end
    end

    assign LDATA     = r_ldata;
    assign RDATA     = r_rdata;
    assign FSCLK     = r_fsclk;
    assign LOCKED    = r_locked;
    assign FRAME_ERR = r_frame_err;

endmodule : i2s_rx_deser
`default_nettype wire

// File: tb/tb_i2s_rx_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_rx_deser
//  Description : Directed self-checking bench for i2s_rx_deser.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_rx_deser;

    localparam int WIDTH = 16;

    logic             MCLK   = 1'b0;
    logic             RST    = 1'b1;
    logic             ABCLK  = 1'b0;
    logic             ALRCLK = 1'b0;
    logic             ADATA  = 1'b0;
    logic [WIDTH-1:0] LDATA;
    logic [WIDTH-1:0] RDATA;
    logic             FSCLK;
    logic             LOCKED;
    logic             FRAME_ERR;

    i2s_rx_deser #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .MCLK      (MCLK),
        .RST       (RST),
        .ABCLK     (ABCLK),
        .ALRCLK    (ALRCLK),
        .ADATA     (ADATA),
        .LDATA     (LDATA),
        .RDATA     (RDATA),
        .FSCLK     (FSCLK),
        .LOCKED    (LOCKED),
        .FRAME_ERR (FRAME_ERR)
    );

    // MCLK period 10: rising edges at 5, 15, 25 ...
    always #5 MCLK = ~MCLK;

    int          total     = 0;
    int          bad       = 0;
    int          fs_cnt    = 0;
    int          fe_cnt    = 0;
    int          fs_consec = 0;
    int          fs_lat    = -1;
    logic [15:0] fs_l      = '0;
    logic [15:0] fs_r      = '0;
    logic        prev_fs   = 1'b0;
    time         rise_t    = 0;
    int          half_bclk = 40;
    logic        pend_d    = 1'b0;

    always @(posedge ABCLK) rise_t = $time;

    // Pulse monitor sampled 1 time unit after each MCLK rising edge.
    always @(posedge MCLK) begin
        #1;
        if (FSCLK === 1'b1) begin
            fs_cnt++;
            fs_l   = LDATA;
            fs_r   = RDATA;
            // MCLK rising edges elapsed since the ABCLK rise
            fs_lat = int'(($time - 1 - rise_t + 5) / 10);
            if (prev_fs) fs_consec++;
        end
        if (FRAME_ERR === 1'b1) fe_cnt++;
        prev_fs = (FSCLK === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One BCLK period. Transmitter changes WS/data on the falling edge; the
    // data line carries the previous bit (one-bit I2S delay relative to WS).
    task automatic bit_out(input logic ws, input logic d);
        ABCLK  = 1'b0;
        ALRCLK = ws;
        ADATA  = pend_d;
        pend_d = d;
        #(half_bclk);
        ABCLK  = 1'b1;
        #(half_bclk);
    endtask

    // Slot bits [from, upto): first nbits are the word MSB first, rest zero.
    task automatic send_slot(input logic ws, input logic [31:0] word, input int nbits,
                             input int from, input int upto);
        logic b;
        for (int k = from; k < upto; k++) begin
            b = 1'b0;
            if (k < nbits) b = word[nbits-1-k];
            bit_out(ws, b);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                              input int nl, input int nr, input int sl, input int sr);
        send_slot(1'b0, l, nl, 0, sl);
        send_slot(1'b1, r, nr, 0, sr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_l;
        logic [15:0] exp_r;
        logic [15:0] nxt_l;
        logic [15:0] nxt_r;

        // ---------------- reset state ----------------
        RST = 1'b1;
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_ldata",  32'(LDATA), 32'h0);
        chk("rst_rdata",  32'(RDATA), 32'h0);
        chk("rst_fsclk",  32'(FSCLK), 32'h0);
        chk("rst_locked", 32'(LOCKED), 32'h0);
        chk("rst_ferr",   32'(FRAME_ERR), 32'h0);
        @(negedge MCLK);
        RST = 1'b0;

        // ---------------- 16-bit words in 32-bit slots ----------------
        // Frame 1 only aligns, frame 2 is captured, published at frame 3 start.
        repeat (3) send_frame(32'h1234, 32'hABCD, 16, 16, 32, 32);
        chk("f16_fs_cnt", 32'(fs_cnt), 32'd1);
        chk("f16_fs_l",   32'(fs_l), 32'h1234);
        chk("f16_fs_r",   32'(fs_r), 32'hABCD);
        chk("f16_ldata",  32'(LDATA), 32'h1234);
        chk("f16_rdata",  32'(RDATA), 32'hABCD);
        chk("f16_locked", 32'(LOCKED), 32'h1);
        // 2 synchronizer stages + 2 cycles from the rise event
        chk("f16_latency", 32'(fs_lat), 32'd4);
        chk("f16_ferr",   32'(fe_cnt), 32'd0);

        // ---------------- 24-bit words truncate to 16 ----------------
        repeat (2) send_frame(32'h7FFF80, 32'h800001, 24, 24, 32, 32);
        chk("f24_fs_cnt", 32'(fs_cnt), 32'd3);
        chk("f24_ldata",  32'(LDATA), 32'h7FFF);
        chk("f24_rdata",  32'(RDATA), 32'h8000);
        chk("f24_ferr",   32'(fe_cnt), 32'd0);

        // ---------------- short (12-bit) right word ----------------
        send_frame(32'h1111, 32'h2222, 16, 16, 32, 32);
        send_frame(32'h3333, 32'h0ABC, 16, 12, 32, 12);
        chk("short_pre_ldata", 32'(LDATA), 32'h1111);
        chk("short_pre_rdata", 32'(RDATA), 32'h2222);
        send_frame(32'h5555, 32'h6666, 16, 16, 32, 32);
        chk("short_ferr",    32'(fe_cnt), 32'd1);
        chk("short_locked",  32'(LOCKED), 32'h0);
        chk("short_ldata",   32'(LDATA), 32'h1111);
        chk("short_rdata",   32'(RDATA), 32'h2222);
        chk("short_fs_cnt",  32'(fs_cnt), 32'd5);
        send_frame(32'h7777, 32'h8888, 16, 16, 32, 32);
        chk("short_seek_fs", 32'(fs_cnt), 32'd5);
        send_frame(32'h9999, 32'hAAAA, 16, 16, 32, 32);
        chk("recov_fs_cnt",  32'(fs_cnt), 32'd6);
        chk("recov_ldata",   32'(LDATA), 32'h7777);
        chk("recov_rdata",   32'(RDATA), 32'h8888);
        chk("recov_locked",  32'(LOCKED), 32'h1);

        // ---------------- reset mid-left-word after lock ----------------
        send_slot(1'b0, 32'h1357, 16, 0, 8);
        chk("prerst_fs_l", 32'(fs_l), 32'h9999);
        RST = 1'b1;
        repeat (2) @(posedge MCLK);
        #1;
        chk("midrst_ldata",  32'(LDATA), 32'h0);
        chk("midrst_rdata",  32'(RDATA), 32'h0);
        chk("midrst_locked", 32'(LOCKED), 32'h0);
        chk("midrst_fsclk",  32'(FSCLK), 32'h0);
        chk("midrst_ferr",   32'(FRAME_ERR), 32'h0);
        @(negedge MCLK);
        RST = 1'b0;
        send_slot(1'b0, 32'h1357, 16, 8, 32);
        send_slot(1'b1, 32'h2468, 16, 0, 32);
        send_frame(32'hCAFE, 32'hBEEF, 16, 16, 32, 32);
        chk("postrst_fs_none", 32'(fs_cnt), 32'd7);
        chk("postrst_ldata0",  32'(LDATA), 32'h0);
        send_frame(32'h0F0F, 32'hF0F0, 16, 16, 32, 32);
        chk("postrst_fs_cnt", 32'(fs_cnt), 32'd8);
        chk("postrst_fs_l",   32'(fs_l), 32'hCAFE);
        chk("postrst_fs_r",   32'(fs_r), 32'hBEEF);
        chk("postrst_locked", 32'(LOCKED), 32'h1);
        chk("postrst_lat",    32'(fs_lat), 32'd4);

        // ---------------- stream starting mid-right-channel ----------------
        RST = 1'b1;
        repeat (2) @(posedge MCLK);
        @(negedge MCLK);
        RST = 1'b0;
        send_slot(1'b1, 32'h4321, 16, 10, 32);
        send_frame(32'h1A2B, 32'h3C4D, 16, 16, 32, 32);
        chk("midr_fs_none", 32'(fs_cnt), 32'd8);
        chk("midr_ldata0",  32'(LDATA), 32'h0);
        chk("midr_rdata0",  32'(RDATA), 32'h0);
        chk("midr_locked0", 32'(LOCKED), 32'h0);
        send_frame(32'h5E6F, 32'h7081, 16, 16, 32, 32);
        chk("midr_fs_cnt", 32'(fs_cnt), 32'd9);
        chk("midr_fs_l",   32'(fs_l), 32'h1A2B);
        chk("midr_fs_r",   32'(fs_r), 32'h3C4D);
        exp_l = 16'h5E6F;
        exp_r = 16'h7081;

        // ---------------- random data, drifting MCLK phase ----------------
        half_bclk = 43;
        #($urandom_range(1, 9));
        for (int f = 0; f < 48; f++) begin
            nxt_l = 16'($urandom);
            nxt_r = 16'($urandom);
            send_frame(32'(nxt_l), 32'(nxt_r), 16, 16, 32, 32);
            chk("rand_ldata", 32'(LDATA), 32'(exp_l));
            chk("rand_rdata", 32'(RDATA), 32'(exp_r));
            exp_l = nxt_l;
            exp_r = nxt_r;
        end
        chk("rand_ferr",     32'(fe_cnt), 32'd1);
        chk("rand_fs_cnt",   32'(fs_cnt), 32'd57);
        chk("rand_locked",   32'(LOCKED), 32'h1);
        chk("fsclk_consec",  32'(fs_consec), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_i2s_rx_deser
`default_nettype wire
